// File: rtl/rc4_encryptor.sv
// RC4 encrypt engine: INIT, KSA, optional keystream drop, then PRGA XOR of plaintext RAM into ciphertext RAM.
// Define RC4_DROP_EN to discard DROP_N keystream bytes after KSA (RC4-drop[n]).
module rc4_encryptor #(
    parameter int RAM_WIDTH          = 8,
    parameter int RAM_LENGTH         = 8,
    parameter int KEY_LENGTH         = 3,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5,
    parameter int DROP_N             = 256
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]    key,
    output logic [RAM_LENGTH-1:0]              sAddr,
    output logic [RAM_WIDTH-1:0]               sIn,
    output logic                               sWren,
    input  logic [RAM_WIDTH-1:0]               sOut,
    output logic [MESSAGE_LOG_LENGTH-1:0]      pAddr,
    input  logic [RAM_WIDTH-1:0]               pOut,
    output logic [MESSAGE_LOG_LENGTH-1:0]      cAddr,
    output logic [RAM_WIDTH-1:0]               cIn,
    output logic                               cWren,
    output logic                               busy,
    output logic                               done
);
    localparam int KW     = KEY_LENGTH * RAM_WIDTH;
    localparam int DROP_W = $clog2(DROP_N + 2);
    localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_K = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
`ifdef RC4_DROP_EN
    localparam logic [DROP_W-1:0] DROP_LOAD = DROP_W'(DROP_N);
`else
    localparam logic [DROP_W-1:0] DROP_LOAD = '0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_INIT,
        S_KSA_RI, S_KSA_RJ, S_KSA_WI, S_KSA_WJ,
        S_PRGA_RI, S_PRGA_RJ, S_PRGA_WI, S_PRGA_WJ, S_PRGA_RF, S_PRGA_WC,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [RAM_LENGTH-1:0]           i_q, i_d, j_q, j_d;
    logic [MESSAGE_LOG_LENGTH-1:0]   k_q, k_d;
    logic [RAM_WIDTH-1:0]            si_q, si_d, sj_q, sj_d;
    logic [KW-1:0]                   key_q, key_d;
    logic [DROP_W-1:0]               drop_q, drop_d;

    logic [RAM_LENGTH-1:0] i_inc, j_ksa, j_prga;
    logic [RAM_WIDTH-1:0]  f_idx;

    // Key register rotates one byte per KSA step, so its top byte is always key[i mod KEY_LENGTH].
    assign i_inc  = i_q + RAM_LENGTH'(1);
    assign j_ksa  = j_q + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_q[KW-1 -: RAM_WIDTH]);
    assign j_prga = j_q + RAM_LENGTH'(sOut);
    assign f_idx  = si_q + sj_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                i_d = i_inc;
                if (i_q == '1) state_d = S_KSA_RI;
            end
            S_KSA_RI: state_d = S_KSA_RJ;
            S_KSA_RJ: begin
                si_d    = sOut;
                j_d     = j_ksa;
                state_d = S_KSA_WI;
            end
            S_KSA_WI: begin
                sj_d    = sOut;
                state_d = S_KSA_WJ;
            end
            S_KSA_WJ: begin
                key_d = {key_q[KW-RAM_WIDTH-1:0], key_q[KW-1 -: RAM_WIDTH]};
                i_d   = i_inc;
                if (i_q == '1) begin
                    j_d     = '0;
                    drop_d  = DROP_LOAD;
                    state_d = S_PRGA_RI;
                end else begin
                    state_d = S_KSA_RI;
                end
            end
            S_PRGA_RI: begin
                i_d     = i_inc;
                state_d = S_PRGA_RJ;
            end
            S_PRGA_RJ: begin
                si_d    = sOut;
                j_d     = j_prga;
                state_d = S_PRGA_WI;
            end
            S_PRGA_WI: begin
                sj_d    = sOut;
                state_d = S_PRGA_WJ;
            end
            // Drop steps end after the swap; i and j carry straight into real PRGA.
            S_PRGA_WJ: begin
                if (drop_q != '0) begin
                    drop_d  = drop_q - DROP_W'(1);
                    state_d = S_PRGA_RI;
                end else begin
                    state_d = S_PRGA_RF;
                end
            end
            S_PRGA_RF: state_d = S_PRGA_WC;
            S_PRGA_WC: begin
                if (k_q == LAST_K) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + MESSAGE_LOG_LENGTH'(1);
                    state_d = S_PRGA_RI;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sAddr = '0;
        sIn   = '0;
        sWren = 1'b0;
        pAddr = '0;
        cAddr = '0;
        cIn   = '0;
        cWren = 1'b0;
        busy  = (state_q != S_IDLE) && (state_q != S_DONE);
        done  = (state_q == S_DONE);
        case (state_q)
            S_INIT: begin
                sAddr = i_q;
                sIn   = RAM_WIDTH'(i_q);
                sWren = 1'b1;
            end
            S_KSA_RI: sAddr = i_q;
            S_KSA_RJ: sAddr = j_ksa;
            // Second swap write uses the captured S[i], so i==j leaves S[i] intact.
            S_KSA_WI, S_PRGA_WI: begin
                sAddr = i_q;
                sIn   = sOut;
                sWren = 1'b1;
                pAddr = (state_q == S_PRGA_WI) ? k_q : '0;
            end
            S_KSA_WJ, S_PRGA_WJ: begin
                sAddr = j_q;
                sIn   = si_q;
                sWren = 1'b1;
                pAddr = (state_q == S_PRGA_WJ) ? k_q : '0;
            end
            S_PRGA_RI: begin
                sAddr = i_inc;
                pAddr = k_q;
            end
            S_PRGA_RJ: begin
                sAddr = j_prga;
                pAddr = k_q;
            end
            S_PRGA_RF: begin
                sAddr = RAM_LENGTH'(f_idx);
                pAddr = k_q;
            end
            S_PRGA_WC: begin
                pAddr = k_q;
                cAddr = k_q;
                cIn   = sOut ^ pOut;
                cWren = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rc4_encryptor.sv
// Scoreboard bench for rc4_encryptor: RAM models, array-based RC4 reference, ciphertext write monitor.
module tb_rc4_encryptor;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] key;
    logic [7:0]  sAddr, sIn, sOut, pOut, cIn;
    logic        sWren, cWren, busy, done;
    logic [4:0]  pAddr, cAddr;

    localparam int BOUND = 256 + 256*6 + 32*8 + 4
`ifdef RC4_DROP_EN
                           + 256*6
`endif
                           ;
`ifdef RC4_DROP_EN
    localparam int DROP = 256;
`else
    localparam int DROP = 0;
`endif

    rc4_encryptor dut (
        .clk(clk), .reset(reset), .start(start), .key(key),
        .sAddr(sAddr), .sIn(sIn), .sWren(sWren), .sOut(sOut),
        .pAddr(pAddr), .pOut(pOut),
        .cAddr(cAddr), .cIn(cIn), .cWren(cWren),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem [256];
    logic [7:0] p_mem [32];
    logic [7:0] c_mem [32];
    logic [7:0] ref_c [32];
    logic [7:0] gold  [9];
    logic [12:0] exp_q [$];
    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int first_lat = 0;

    always @(posedge clk) begin
        if (sWren) s_mem[sAddr] <= sIn;
        sOut <= s_mem[sAddr];
        pOut <= p_mem[pAddr];
        if (cWren) c_mem[cAddr] <= cIn;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && cWren) begin
            logic [12:0] e;
            pulse_cnt++;
            chk("s_c_wren_exclusive", int'(sWren), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_c_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("c_addr_order", int'(cAddr), int'(e[12:8]));
                chk("c_data", int'(cIn), int'(e[7:0]));
            end
        end
    end

    // Straight textbook RC4 over plain arrays.
    task automatic model_push(input logic [23:0] k);
        int s [256];
        int kb [3];
        int i, j, t;
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + kb[a % 3]) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int n = 0; n < DROP + 32; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (n >= DROP) begin
                ref_c[n-DROP] = 8'(s[(s[i] + s[j]) % 256]) ^ p_mem[n-DROP];
                exp_q.push_back({5'(n - DROP), ref_c[n-DROP]});
            end
        end
    endtask

    task automatic start_pulse(input logic [23:0] k);
        @(posedge clk); #1;
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        key   = 24'($urandom);
    endtask

    task automatic run(input logic [23:0] k, input bit poke);
        int lat;
        model_push(k);
        pulse_cnt = 0;
        start_pulse(k);
        lat = 0;
        while (!done && lat < 3000) begin
            if (poke && (lat == 50 || lat == 700)) begin
                key   = 24'hA5A5A5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("done_reached", int'(done), 1);
        chk("busy_low_at_done", int'(busy), 0);
        chk("latency_within_bound", int'(lat <= BOUND), 1);
        if (first_lat == 0) first_lat = lat;
        else chk("latency_deterministic", lat, first_lat);
        chk("cwren_pulse_count", pulse_cnt, 32);
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 32; n++) chk("c_mem_vs_model", int'(c_mem[n]), int'(ref_c[n]));
    endtask

    task automatic load_plaintext();
        string pt;
        pt = "Plaintext";
        for (int n = 0; n < 32; n++) p_mem[n] = (n < 9) ? pt[n] : 8'h00;
    endtask

    task automatic check_gold();
`ifdef RC4_DROP_EN
        int same;
        same = 1;
        for (int n = 0; n < 9; n++) if (c_mem[n] != gold[n]) same = 0;
        chk("drop_differs_from_plain_rc4", same, 0);
`else
        for (int n = 0; n < 9; n++) chk("known_vector", int'(c_mem[n]), int'(gold[n]));
`endif
    endtask

    initial begin
        gold = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        reset = 1'b1;
        start = 1'b0;
        key   = '0;
        for (int n = 0; n < 32; n++) begin
            p_mem[n] = 8'h00;
            c_mem[n] = 8'h00;
        end
        #3;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_swren", int'(sWren), 0);
        chk("reset_cwren", int'(cWren), 0);
        chk("reset_saddr", int'(sAddr), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Known vector "Key"/"Plaintext"
        load_plaintext();
        run(24'h4B6579, 1'b0);
        check_gold();

        // Start pulses with another key while busy must be ignored
        run(24'h4B6579, 1'b1);
        check_gold();

        // Reset partway through KSA
        start_pulse(24'h4B6579);
        repeat (400) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_swren", int'(sWren), 0);
        chk("abort_saddr", int'(sAddr), 0);
        chk("abort_sin", int'(sIn), 0);
        chk("abort_cwren", int'(cWren), 0);
        chk("abort_paddr", int'(pAddr), 0);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_abort", int'(busy), 0);
        for (int n = 0; n < 32; n++) c_mem[n] = 8'h00;
        run(24'h4B6579, 1'b0);
        check_gold();

        // Round trip: encrypting the ciphertext recovers the plaintext
        for (int n = 0; n < 32; n++) p_mem[n] = 8'(n);
        run(24'h0003FF, 1'b0);
        for (int n = 0; n < 32; n++) p_mem[n] = c_mem[n];
        run(24'h0003FF, 1'b0);
        for (int n = 0; n < 32; n++) chk("round_trip", int'(c_mem[n]), n);

        // Random keys and plaintexts
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 32; n++) p_mem[n] = 8'($urandom);
            run(24'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
